// File: rtl/debug_tx_pkg.sv
// Shared types and constants for the debug-port UART packet transmitter.
package debug_tx_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned NUM_DATA_BYTES = 7;

endpackage

// File: rtl/debug_port_tx_if.sv
// Trigger, captured debug bytes and serial/status outputs of debug_port_tx.
interface debug_port_tx_if;
  logic       trigger;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output trigger, debug_port1, debug_port2, debug_port3, debug_port4, debug_port5,
           debug_port6, debug_port7,
    input  tx, busy, done
  );

  modport slave (
    input  trigger, debug_port1, debug_port2, debug_port3, debug_port4, debug_port5,
           debug_port6, debug_port7,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a bit-period counter; byte_done_o marks the last cycle of the stop bit
// so the caller can chain the next byte without an idle gap.
module uart_tx_byte
  import debug_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  tx_state_e        state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end     = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign byte_done_o = (state_q == StStop) && bit_end;
  assign tx_o        = tx_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            state_q <= StStart;
            shift_q <= data_i;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              bit_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            // Chaining straight into the next start bit keeps bytes back-to-back.
            if (load_i) begin
              state_q <= StStart;
              shift_q <= data_i;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/debug_port_tx.sv
// Snapshots seven debug bytes on trigger and sends them as a sync-prefixed 8N1 UART packet.
// Define DEBUG_PORT_TX_CHECKSUM_EN to append an XOR checksum of the seven data bytes.
module debug_port_tx
  import debug_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             nreset,
  debug_port_tx_if.slave   bus
);

`ifdef DEBUG_PORT_TX_CHECKSUM_EN
  localparam int unsigned NumBytes = NUM_DATA_BYTES + 2;
`else
  localparam int unsigned NumBytes = NUM_DATA_BYTES + 1;
`endif
  localparam int unsigned IdxW  = $clog2(NumBytes);
  localparam int unsigned SnapW = $clog2(NUM_DATA_BYTES);

  logic [7:0]      snap_q [NUM_DATA_BYTES];
  logic [IdxW-1:0] idx_q;
  logic            busy_q;
  logic            done_q;

  logic [IdxW-1:0]  next_idx;
  logic [SnapW-1:0] snap_idx;
  logic [7:0]       byte_data;
  logic             start;
  logic             last_byte;
  logic             load;
  logic             byte_done;
  logic             tx;

  assign start     = bus.trigger && !busy_q;
  assign last_byte = (idx_q == IdxW'(NumBytes - 1));
  assign load      = start || (byte_done && !last_byte);

`ifdef DEBUG_PORT_TX_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_DATA_BYTES; i++) begin
      csum = csum ^ snap_q[i];
    end
  end
`endif

  // The byte mux looks one byte ahead: it selects what the serialiser loads on this edge.
  always_comb begin
    next_idx  = start ? '0 : idx_q + IdxW'(1);
    snap_idx  = SnapW'(next_idx - IdxW'(1));
    byte_data = snap_q[snap_idx];
    if (next_idx == '0) begin
      byte_data = SYNC_BYTE;
    end
`ifdef DEBUG_PORT_TX_CHECKSUM_EN
    else if (next_idx == IdxW'(NumBytes - 1)) begin
      byte_data = csum;
    end
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      for (int i = 0; i < NUM_DATA_BYTES; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q    <= 1'b1;
        idx_q     <= '0;
        snap_q[0] <= bus.debug_port1;
        snap_q[1] <= bus.debug_port2;
        snap_q[2] <= bus.debug_port3;
        snap_q[3] <= bus.debug_port4;
        snap_q[4] <= bus.debug_port5;
        snap_q[5] <= bus.debug_port6;
        snap_q[6] <= bus.debug_port7;
      end else if (byte_done) begin
        if (last_byte) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IdxW'(1);
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .nreset     (nreset),
    .load_i     (load),
    .data_i     (byte_data),
    .tx_o       (tx),
    .byte_done_o(byte_done)
  );

  assign bus.tx   = tx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/debug_port_tx.md
DEBUG_PORT_TX -- requirements
Module: debug_port_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit; legal range 2..65535.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 nreset  input  1  reset; asynchronous assert, active-low.
REQ-004 trigger  input  1  snapshot-and-send request; level sampled each clk edge.
REQ-005 debug_port1..debug_port7  input  8 each  CPU debug bytes to capture.
REQ-006 tx  output  1  UART serial line, 8N1, idle high.
REQ-007 busy  output  1  high while a packet is captured or in flight.
REQ-008 done  output  1  one-cycle pulse when a packet's final stop bit completes.

Function
REQ-009 Packet SHALL be byte sequence: sync 0xA5, then debug_port1 through debug_port7 in order (8 bytes total, 9 with checksum per REQ-021).
REQ-010 Each byte SHALL be framed as start bit 0, 8 data bits LSB first, stop bit 1; every bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-011 Bytes SHALL be sent back-to-back with no idle bits between stop and next start bit.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on trigger=1; START->DATA after one bit time; DATA->STOP after 8 bit times; STOP->START if bytes remain, else STOP->IDLE.
REQ-013 Trigger sampled high in IDLE SHALL capture all seven debug ports into an internal snapshot on that same edge; later port changes SHALL NOT affect the packet.
REQ-014 busy SHALL rise on the capturing edge and tx SHALL be 0 (start bit of sync byte) from that edge onward.
REQ-015 Trigger while busy=1 SHALL be ignored (not queued); trigger held high continuously SHALL start a new packet on the first edge in IDLE after done.
REQ-016 On completion of the last stop bit, done SHALL pulse for exactly one cycle and busy SHALL fall on the same edge.
REQ-017 Packet latency: capturing edge to done edge SHALL be 80*CLKS_PER_BIT cycles (90*CLKS_PER_BIT with checksum).
REQ-018 Baud counter and bit counter SHALL wrap to 0 at each bit/byte boundary; no counter SHALL overflow for any legal CLKS_PER_BIT.

Reset
REQ-019 While nreset=0: tx=1, busy=0, done=0, FSM=IDLE, all counters and snapshot=0.
REQ-020 Reset asserted mid-packet SHALL abort immediately (tx to 1 asynchronously); after release no partial packet resumes and next trigger starts a fresh packet.

Configuration
REQ-021 Macro DEBUG_PORT_TX_CHECKSUM_EN defined: a ninth byte equal to XOR of the seven captured data bytes (sync excluded) SHALL follow debug_port7; undefined: packet SHALL be exactly 8 bytes and no checksum logic SHALL exist.

Structure
REQ-022 Shared package debug_tx_pkg SHALL hold the FSM state typedef, SYNC_BYTE=0xA5 and data-byte count constant 7.
REQ-023 One sub-module uart_tx_byte (load byte, shift 8N1 with baud counter, report byte-done) SHALL be instantiated; debug_port_tx SHALL own packet sequencing and snapshot.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-024 Ports 1..7 = 0x01..0x07, trigger 1 cycle -> tx decodes A5 01 02 03 04 05 06 07; done pulses exactly 320 cycles after capture; busy low thereafter.
REQ-025 Trigger then change all ports to 0xFF next cycle -> transmitted data bytes still 0x01..0x07.
REQ-026 Retrigger at cycle 100 of a packet -> ignored, one packet only; trigger held high -> second packet starts the edge after done, no idle gap beyond 1 cycle.
REQ-027 nreset low at cycle 150 of a packet -> tx=1, busy=0 immediately; after release trigger -> complete fresh packet starting with 0xA5.
REQ-028 With DEBUG_PORT_TX_CHECKSUM_EN, port1=0x5A, others 0x00 -> bytes A5 5A 00 00 00 00 00 00 5A; done at 360 cycles.
REQ-029 CLKS_PER_BIT=2 and 434 -> every bit width measured equals parameter exactly; packet frame correct.
